// File: rtl/task_scheduler_gen.sv
// rtl/task_scheduler_gen.sv - task scheduler: fetches CF/IF frames from task memory and launches core groups
module task_scheduler_gen #(
  parameter int NUM_CORES = 16,
  parameter int TM_DEPTH  = 64,
  parameter int INSN_W    = 16,
  parameter int LOAD_TIME = 16,
  parameter int REG_W     = 8,
  parameter int IFN_W     = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tm_wr_en,
  input  logic [$clog2(TM_DEPTH)-1:0]     tm_wr_addr,
  input  logic [LOAD_TIME*INSN_W-1:0]     tm_wr_data,
  input  logic                            run,
  input  logic [NUM_CORES-1:0]            ready,
  output logic [$clog2(LOAD_TIME)-1:0]    insn_load_counter,
  output logic [INSN_W-1:0]               insn_data,
  output logic [NUM_CORES-1:0]            start,
  output logic [NUM_CORES-1:0]            init_r0_vect,
  output logic [NUM_CORES*REG_W-1:0]      init_r0,
  output logic                            busy,
  output logic                            done
);
  localparam int PTR_W    = $clog2(TM_DEPTH);
  localparam int FRAME_W  = LOAD_TIME * INSN_W;
  localparam int CNT_W    = $clog2(LOAD_TIME);
  localparam int IFN_LSB  = 2;
  localparam int HALT_BIT = IFN_LSB + IFN_W;
  localparam int MASK_LSB = HALT_BIT + 1;
  localparam int R0V_LSB  = MASK_LSB + NUM_CORES;
  localparam int R0_LSB   = R0V_LSB + NUM_CORES;
  localparam logic [1:0] F_ACQ = 2'd1;
  localparam logic [1:0] F_REL = 2'd2;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LOAD_TIME - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_LAUNCH, S_HOLD, S_WAITC, S_RELW, S_DONE
  } state_t;

  state_t state, state_d;

  logic [FRAME_W-1:0]   tm [TM_DEPTH];
  logic [FRAME_W-1:0]   frame;
  logic [PTR_W-1:0]     ptr;
  logic [CNT_W-1:0]     word;
  logic                 hold_cnt;
  logic [IFN_W-1:0]     remaining;
  logic [NUM_CORES-1:0] mask_r;
  logic [1:0]           fence_r;
  logic                 run_q;

  logic [1:0]           cf_fence;
  logic [IFN_W-1:0]     cf_ifn;
  logic                 cf_halt;
  logic [NUM_CORES-1:0] cf_mask;
  logic                 cf_ok;
  logic                 mask_ok;
  logic                 run_rise;
  logic                 run_start;
  logic                 cf_accept;
  logic                 launch_fire;
  logic                 ptr_inc;

  // Asynchronous read: a write in the same cycle lands at the edge, so the FSM sees old data.
  always_ff @(posedge clk) begin
    if (tm_wr_en) tm[tm_wr_addr] <= tm_wr_data;
  end

  assign frame    = tm[ptr];
  assign cf_fence = frame[1:0];
  assign cf_ifn   = frame[IFN_LSB +: IFN_W];
  assign cf_halt  = frame[HALT_BIT];
  assign cf_mask  = frame[MASK_LSB +: NUM_CORES];
  assign cf_ok    = (cf_fence == F_ACQ) ? (&ready) : ((ready & cf_mask) == cf_mask);
  assign mask_ok  = (ready & mask_r) == mask_r;
  assign run_rise = run && !run_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_DONE: if (run_rise) state_d = S_FETCH;
      S_FETCH: begin
        if (cf_halt)
          state_d = S_DONE;
        else if (cf_ok) begin
          if (cf_ifn != '0)          state_d = S_LOAD;
          else if (cf_fence == F_REL) state_d = S_RELW;
          else                        state_d = S_FETCH;
        end
      end
      S_LOAD:   if (word == LAST_WORD) state_d = S_LAUNCH;
      S_LAUNCH: if (mask_ok) state_d = S_HOLD;
      S_HOLD: begin
        if (hold_cnt) begin
          if (remaining != '0)       state_d = S_WAITC;
          else if (fence_r == F_REL) state_d = S_RELW;
          else                       state_d = S_FETCH;
        end
      end
      S_WAITC:  if (mask_ok) state_d = S_LOAD;
      S_RELW:   if (&ready) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = !(state == S_IDLE || state == S_DONE);
    done        = (state == S_DONE);
    run_start   = !busy && run_rise;
    cf_accept   = (state == S_FETCH) && !cf_halt && cf_ok;
    launch_fire = (state == S_LAUNCH) && mask_ok;
    ptr_inc     = cf_accept || ((state == S_LOAD) && (word == LAST_WORD));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr               <= '0;
      word              <= '0;
      hold_cnt          <= 1'b0;
      remaining         <= '0;
      mask_r            <= '0;
      fence_r           <= '0;
      run_q             <= 1'b0;
      start             <= '0;
      init_r0_vect      <= '0;
      init_r0           <= '0;
      insn_data         <= '0;
      insn_load_counter <= LAST_WORD;
    end else begin
      run_q    <= run;
      start    <= launch_fire ? mask_r : '0;
      hold_cnt <= (state == S_HOLD) ? ~hold_cnt : 1'b0;
      word     <= ((state == S_LOAD) && (word != LAST_WORD)) ? word + 1'b1 : '0;
      if (run_start)    ptr <= '0;
      else if (ptr_inc) ptr <= ptr + 1'b1;
      if (cf_accept) begin
        mask_r       <= cf_mask;
        fence_r      <= cf_fence;
        remaining    <= cf_ifn;
        init_r0_vect <= frame[R0V_LSB +: NUM_CORES];
        init_r0      <= frame[R0_LSB +: NUM_CORES*REG_W];
      end else if (launch_fire) begin
        remaining <= remaining - 1'b1;
      end
      if (state == S_LOAD) begin
        insn_data         <= frame[word*INSN_W +: INSN_W];
        insn_load_counter <= word;
      end
    end
  end
endmodule

// File: tb/tb_task_scheduler_gen.sv
// tb/tb_task_scheduler_gen.sv - scoreboard bench for task_scheduler_gen
module tb_task_scheduler_gen;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         tm_wr_en = 1'b0;
  logic [5:0]   tm_wr_addr = '0;
  logic [255:0] tm_wr_data = '0;
  logic         run = 1'b0;
  logic [15:0]  ready = 16'hFFFF;
  logic [3:0]   insn_load_counter;
  logic [15:0]  insn_data;
  logic [15:0]  start;
  logic [15:0]  init_r0_vect;
  logic [127:0] init_r0;
  logic         busy;
  logic         done;

  int n_run = 0;
  int n_fail = 0;
  logic [19:0] exp_words[$];
  logic [15:0] exp_starts[$];
  logic [3:0]  prev_cnt = 4'hF;

  task_scheduler_gen dut (
    .clk(clk), .reset(reset), .tm_wr_en(tm_wr_en), .tm_wr_addr(tm_wr_addr),
    .tm_wr_data(tm_wr_data), .run(run), .ready(ready),
    .insn_load_counter(insn_load_counter), .insn_data(insn_data), .start(start),
    .init_r0_vect(init_r0_vect), .init_r0(init_r0), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mk_cf(input logic [1:0] fence, input logic [7:0] ifn,
      input logic halt, input logic [15:0] mask, input logic [15:0] r0v, input logic [127:0] r0);
    logic [255:0] f = '0;
    f[1:0]    = fence;
    f[9:2]    = ifn;
    f[10]     = halt;
    f[26:11]  = mask;
    f[42:27]  = r0v;
    f[170:43] = r0;
    return f;
  endfunction

  function automatic logic [255:0] mk_if(input logic [7:0] seed);
    logic [255:0] f;
    for (int k = 0; k < 16; k++) f[k*16 +: 16] = {seed ^ 8'(k * 3), 8'(k)};
    return f;
  endfunction

  task automatic push_if(input logic [255:0] fr, input logic [15:0] mask);
    for (int k = 0; k < 16; k++) exp_words.push_back({4'(k), fr[k*16 +: 16]});
    if (mask != 0) exp_starts.push_back(mask);
  endtask

  task automatic tm_write(input logic [5:0] addr, input logic [255:0] data);
    @(negedge clk);
    tm_wr_en = 1'b1; tm_wr_addr = addr; tm_wr_data = data;
    @(negedge clk);
    tm_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; run = 1'b0; ready = 16'hFFFF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    check(tag, done, 1'b1);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (start == 0 && n < 200) begin @(negedge clk); n++; end
    check(tag, start != 0, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_start"}, start, 0);
    check({tag, "_data"}, insn_data, 0);
    check({tag, "_cnt"}, insn_load_counter, 4'hF);
    check({tag, "_r0v"}, init_r0_vect, 0);
    check({tag, "_r0"}, init_r0, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_words_left"}, exp_words.size(), 0);
    check({tag, "_starts_left"}, exp_starts.size(), 0);
  endtask

  // Scoreboard: a new insn_load_counter value marks one streamed word.
  always @(negedge clk) begin
    if (reset) begin
      prev_cnt = insn_load_counter;
    end else begin
      if (insn_load_counter != prev_cnt) begin
        if (exp_words.size() == 0) check("word_expected", exp_words.size(), 1);
        else check("word", {insn_load_counter, insn_data}, exp_words.pop_front());
      end
      prev_cnt = insn_load_counter;
      if (start != 0) begin
        if (exp_starts.size() == 0) check("start_expected", exp_starts.size(), 1);
        else check("start", start, exp_starts.pop_front());
      end
    end
  end

  initial begin
    logic [255:0] f;
    logic [3:0]   pc;
    int           cnt_hits;
    int           n;

    do_reset();
    check_idle_outputs("rst");

    // Test 1: single IF, then halt
    f = mk_if(8'h10);
    tm_write(0, mk_cf(2'd0, 8'd1, 1'b0, 16'h0003, 16'h0001, 128'h5A));
    tm_write(1, f);
    tm_write(2, mk_cf(2'd0, 8'd0, 1'b1, 16'h0, 16'h0, 128'h0));
    push_if(f, 16'h0003);
    start_run();
    check("t1_busy", busy, 1'b1);
    wait_done("t1_done", 200);
    check("t1_r0", init_r0, 128'h5A);
    check("t1_r0v", init_r0_vect, 16'h0001);
    check("t1_busy_done", busy, 1'b0);
    check_drained("t1");

    // Test 2: three IFs, core0 busy for 10 cycles after each start
    do_reset();
    tm_write(0, mk_cf(2'd0, 8'd3, 1'b0, 16'h0001, 16'h0, 128'h0));
    for (int i = 1; i <= 3; i++) begin
      f = mk_if(8'(8'h20 + i));
      tm_write(6'(i), f);
      push_if(f, 16'h0001);
    end
    tm_write(4, mk_cf(2'd0, 8'd0, 1'b1, 16'h0, 16'h0, 128'h0));
    start_run();
    for (int i = 0; i < 3; i++) begin
      wait_start("t2_start_seen");
      ready = 16'hFFFE;
      cnt_hits = 0;
      pc = insn_load_counter;
      repeat (10) begin
        @(negedge clk);
        if (insn_load_counter != pc) cnt_hits++;
        pc = insn_load_counter;
      end
      ready = 16'hFFFF;
      check("t2_no_load_while_core0_busy", cnt_hits, 0);
    end
    wait_done("t2_done", 300);
    check_drained("t2");

    // Test 3: NO accepts with core5 busy, ACQ waits; write to the fetched frame in accept cycle
    do_reset();
    tm_write(0, mk_cf(2'd0, 8'd0, 1'b0, 16'h0001, 16'h00A1, 128'h11));
    tm_write(1, mk_cf(2'd1, 8'd0, 1'b0, 16'h0001, 16'h00B2, 128'h22));
    tm_write(2, mk_cf(2'd0, 8'd0, 1'b1, 16'h0, 16'h0, 128'h0));
    ready = 16'hFFDF;
    start_run();
    repeat (20) @(negedge clk);
    check("t3_no_fence_accepted", init_r0_vect, 16'h00A1);
    check("t3_acq_stalled_busy", busy, 1'b1);
    ready = 16'hFFFF;
    tm_wr_en = 1'b1; tm_wr_addr = 6'd1;
    tm_wr_data = mk_cf(2'd1, 8'd0, 1'b0, 16'h0001, 16'h00FF, 128'h33);
    @(negedge clk);
    tm_wr_en = 1'b0;
    check("t3_old_frame_used", init_r0_vect, 16'h00B2);
    check("t3_old_r0", init_r0, 128'h22);
    wait_done("t3_done", 50);

    // Test 4: REL fence holds the next CF until every core is ready
    do_reset();
    f = mk_if(8'h44);
    tm_write(0, mk_cf(2'd2, 8'd1, 1'b0, 16'h0001, 16'h0003, 128'h0));
    tm_write(1, f);
    tm_write(2, mk_cf(2'd0, 8'd0, 1'b0, 16'h0002, 16'h000C, 128'h0));
    tm_write(3, mk_cf(2'd0, 8'd0, 1'b1, 16'h0, 16'h0, 128'h0));
    push_if(f, 16'h0001);
    start_run();
    wait_start("t4_start_seen");
    ready = 16'hFFFE;
    cnt_hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (init_r0_vect == 16'h000C) cnt_hits++;
    end
    check("t4_rel_fence_hold", cnt_hits, 0);
    ready = 16'hFFFF;
    wait_done("t4_done", 50);
    check("t4_second_cf", init_r0_vect, 16'h000C);
    check_drained("t4");

    // Test 5: program wraps 62 -> 63 -> 0; mask 0 group streams silently
    do_reset();
    f = mk_cf(2'd0, 8'd61, 1'b0, 16'h0, 16'h0, 128'h0);
    f[255:171] = 85'h1A5A5_0F0F0_C3C3C_99999;
    tm_write(0, f);
    for (int i = 1; i <= 61; i++) begin
      f = mk_if(8'(i));
      if (i == 1) f[10] = 1'b1;
      tm_write(6'(i), f);
      push_if(f, 16'h0);
    end
    tm_write(62, mk_cf(2'd0, 8'd2, 1'b0, 16'h0003, 16'h0030, 128'h7));
    f = mk_if(8'hC3);
    tm_write(63, f);
    push_if(f, 16'h0003);
    f = mk_cf(2'd0, 8'd61, 1'b0, 16'h0, 16'h0, 128'h0);
    f[255:171] = 85'h1A5A5_0F0F0_C3C3C_99999;
    push_if(f, 16'h0003);
    start_run();
    wait_done("t5_done", 3000);
    check("t5_r0v", init_r0_vect, 16'h0030);
    check_drained("t5");

    // Test 6: reset during LOAD word 7, then replay from frame 0
    do_reset();
    f = mk_if(8'h66);
    tm_write(0, mk_cf(2'd0, 8'd1, 1'b0, 16'h0001, 16'h0001, 128'h77));
    tm_write(1, f);
    tm_write(2, mk_cf(2'd0, 8'd0, 1'b1, 16'h0, 16'h0, 128'h0));
    push_if(f, 16'h0001);
    start_run();
    n = 0;
    while (insn_load_counter != 4'd7 && n < 200) begin @(negedge clk); n++; end
    check("t6_reached_word7", insn_load_counter, 4'd7);
    check("t6_busy_pre", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("t6_after_reset");
    exp_words.delete();
    exp_starts.delete();
    @(negedge clk);
    reset = 1'b0;
    push_if(f, 16'h0001);
    start_run();
    wait_done("t6_replay_done", 200);
    check("t6_replay_r0", init_r0, 128'h77);
    check_drained("t6");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
